// File: rtl/mult_div_unit.sv
// Signed 32-bit multiply/divide unit (shift-add multiply, restoring divide); optional MULT_DIV_UNSIGNED_EN adds is_unsigned.
// Latency: done pulses 32 clocks after the start edge (1 clock for divide-by-zero).
// Backpressure: none; starts are ignored while busy, and the control FSM waits on busy/done.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MULT   = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] op_mag;
    logic             neg_res;
    logic             neg_rem;

    logic             op_uns;
`ifdef MULT_DIV_UNSIGNED_EN
    assign op_uns = is_unsigned;
`else
    assign op_uns = 1'b0;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = !op_uns && a_in[WIDTH-1];
    assign b_neg = !op_uns && b_in[WIDTH-1];
    assign a_mag = a_neg ? -a_in : a_in;
    assign b_mag = b_neg ? -b_in : b_in;

    // Multiply step: {acc_hi,acc_lo} holds partial product over the multiplier still shifting out.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_mag} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Divide step: acc_hi is the partial remainder; a remainder MSB of 1 means the shifted value overflows WIDTH and must subtract.
    logic [WIDTH-1:0] div_shl, div_hi, div_lo;
    logic             div_ge;
    assign div_shl = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    assign div_ge  = acc_hi[WIDTH-1] || (div_shl >= op_mag);
    assign div_hi  = div_ge ? (div_shl - op_mag) : div_shl;
    assign div_lo  = {acc_lo[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod, prod_fin;
    logic [WIDTH-1:0]   quo_fin, rem_fin;
    assign prod     = {mul_hi, mul_lo};
    assign prod_fin = neg_res ? -prod : prod;
    assign quo_fin  = neg_res ? -div_lo : div_lo;
    assign rem_fin  = neg_rem ? -div_hi : div_hi;

    logic last_iter;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            op_mag   <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_mult || start_div) begin
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= start_mult ? b_mag : a_mag;
                        op_mag   <= start_mult ? a_mag : b_mag;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        if (start_mult)
                            state <= S_MULT;
                        else if (b_in == '0)
                            state <= S_FINISH;
                        else
                            state <= S_DIV;
                    end
                end
                S_MULT: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        {hi_out, lo_out} <= prod_fin;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        state            <= S_IDLE;
                    end
                end
                S_DIV: begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        hi_out <= rem_fin;
                        lo_out <= quo_fin;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                S_FINISH: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized back-to-back operations against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        is_uns = 1'b0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .reset(reset),
        .start_mult(start_mult),
        .start_div(start_div),
        .a_in(a_in),
        .b_in(b_in),
`ifdef MULT_DIV_UNSIGNED_EN
        .is_unsigned(is_uns),
`endif
        .hi_out(hi_out),
        .lo_out(lo_out),
        .busy(busy),
        .done(done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Caller is at posedge+1; E0 is the next edge. track=0 means the op will be aborted.
    task automatic issue(input bit mult, input logic [31:0] a, input logic [31:0] b,
                         input bit uns, input bit track);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb_, q, r;
        sa  = $signed(a);
        sb_ = $signed(b);
        e.dz = 1'b0;
        if (mult) begin
            if (uns) p = {32'b0, a} * {32'b0, b};
            else     p = sa * sb_;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
        end else if (uns) begin
            e.lo = a / b;
            e.hi = a % b;
        end else begin
            q = sa / sb_;
            r = sa % sb_;
            p = q;
            e.lo = p[31:0];
            p = r;
            e.hi = p[31:0];
        end
        e.due = cyc + 1 + (e.dz ? 1 : 32);
        if (track) begin
            sb.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        start_mult = mult;
        start_div  = !mult;
        a_in       = a;
        b_in       = b;
        is_uns     = uns;
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in       = $urandom;
        b_in       = $urandom;
    endtask

    // Returns at posedge+1 of the done cycle; optionally pulses a start while busy.
    task automatic wait_done(input int inject, output int nbusy);
        nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (start_mult || start_div) begin
                start_mult = 1'b0;
                start_div  = 1'b0;
            end
            if (done) return;
            if (busy) nbusy++;
            if (inject != 0 && i == inject) begin
                start_mult = $urandom_range(0, 1);
                start_div  = !start_mult;
                a_in       = $urandom;
                b_in       = $urandom;
            end
        end
        check("done_timeout", {63'b0, done}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi_out", {32'b0, hi_out}, {32'b0, e.hi});
                check("lo_out", {32'b0, lo_out}, {32'b0, e.lo});
                check("div_zero", {63'b0, div_zero}, {63'b0, e.dz});
                check("latency_cycle", cyc, e.due);
                check("busy_at_done", {63'b0, busy}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [31:0] specials [5];
    initial begin
        int          nb, bc, gap, inj;
        bit          mult, uns;
        logic [31:0] a, b;
        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

        #2;
        check("rst_hi", {32'b0, hi_out}, 64'd0);
        check("rst_lo", {32'b0, lo_out}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_div_zero", {63'b0, div_zero}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        issue(1'b1, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b1);
        bc = busy ? 1 : 0;
        wait_done(0, nb);
        check("busy_cycles", bc + nb, 32);
        check("m7x-3_hi", {32'b0, hi_out}, 64'hFFFFFFFF);
        check("m7x-3_lo", {32'b0, lo_out}, 64'hFFFFFFEB);

        issue(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
        wait_done(0, nb);
        check("mmax_hi", {32'b0, hi_out}, 64'h3FFFFFFF);
        check("mmax_lo", {32'b0, lo_out}, 64'h00000001);

        issue(1'b0, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
        wait_done(0, nb);
        check("d-7/2_lo", {32'b0, lo_out}, 64'hFFFFFFFD);
        check("d-7/2_hi", {32'b0, hi_out}, 64'hFFFFFFFF);

        issue(1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_done(0, nb);
        check("dovf_lo", {32'b0, lo_out}, 64'h80000000);
        check("dovf_hi", {32'b0, hi_out}, 64'h0);

        issue(1'b0, 32'h451, 32'h20, 1'b0, 1'b1);
        wait_done(0, nb);
        issue(1'b0, 32'd100, 32'd0, 1'b0, 1'b1);
        wait_done(0, nb);
        check("dz_hi_kept", {32'b0, hi_out}, 64'h11);
        check("dz_lo_kept", {32'b0, lo_out}, 64'h22);
        check("dz_flag", {63'b0, div_zero}, 64'd1);
        @(posedge clk); #1;
        check("dz_flag_held", {63'b0, div_zero}, 64'd1);

        // Aborted multiply: the ignored divide and the reset must produce no done.
        issue(1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        start_div = 1'b1; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk); #1;
        start_div = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hi", {32'b0, hi_out}, 64'd0);
        check("abort_lo", {32'b0, lo_out}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check("abort_no_done", {63'b0, done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 32'd3, 32'd4, 1'b0, 1'b1);
        wait_done(0, nb);
        check("m3x4_lo", {32'b0, lo_out}, 64'd12);
        check("m3x4_hi", {32'b0, hi_out}, 64'd0);

        // Random ops; gap 0 issues the next start in the done cycle itself.
        for (int k = 0; k < 60; k++) begin
            mult = $urandom_range(0, 1);
            a = ($urandom_range(0, 5) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 5) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
`ifdef MULT_DIV_UNSIGNED_EN
            uns = $urandom_range(0, 1);
`else
            uns = 1'b0;
`endif
            inj = (!mult && b == 32'd0) ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : 0);
            issue(mult, a, b, uns, 1'b1);
            wait_done(inj, nb);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
